lc3_mio_arbiter: RTL

//  Sequences the LC3 memory/IO unit (MAR, MDR, memory, KBSR/KBDR/DSR/DDR) for two requesters.

---
 rtl/lc3_mio_arbiter.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lc3_mio_arbiter.sv
// lc3_mio_arbiter: two-port sequencer for the LC3 memory/IO unit (MAR, MDR, memory, KBSR/KBDR/DSR/DDR).
// Port 0 is the CPU control FSM and port 1 is the debug/loader port. One transaction is granted at a time.
// The arbiter drives the DATABUS source and the LD_MAR/LD_MDR/MIO_EN/R_W/GateMDR strobes.
// Optional feature: define LC3_MIO_ARB_TIMEOUT_EN to add a wait-for-R watchdog.
// The watchdog aborts an access after TO_CYC not-ready cycles and reports it with err.
module lc3_mio_arbiter #(
    parameter bit          RR_EN  = 1'b1,
    parameter int unsigned TO_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [15:0] bus_out,
    output logic        bus_en,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        MIO_EN,
    output logic        R_W,
    output logic        GateMDR,
    input  logic [15:0] MDRbus,
    input  logic        R
);

    localparam int unsigned DW = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_ACC   = 3'd3,
        S_RD    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
    } xact_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic          grant_c;
    xact_t         xact_q, xact_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          bus_en_q, bus_en_d;
    logic [DW-1:0] bus_out_q, bus_out_d;
    logic          ld_mar_q, ld_mar_d;
    logic          ld_mdr_wr_q, ld_mdr_wr_d;
    logic          mio_en_q, mio_en_d;
    logic          r_w_q, r_w_d;
    logic          acc_rd_q, acc_rd_d;
    logic          gate_mdr_q, gate_mdr_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic          busy_q, busy_d;

`ifdef LC3_MIO_ARB_TIMEOUT_EN
    localparam int unsigned   CW       = 8;
    localparam logic [CW-1:0] TO_LAST  = CW'(TO_CYC - 1);
    localparam logic [DW-1:0] TO_RDATA = 16'hDEAD;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`else
    logic unused_to_cyc;
    assign unused_to_cyc = ^TO_CYC;
`endif

    // Next-state: arbitration in IDLE, sequencing through the access, read data capture
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        xact_d  = xact_q;
        rdata_d = rdata_q;
        grant_c = 1'b0;
`ifdef LC3_MIO_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        grant_c = RR_EN ? ~last_q : 1'b0;
                    end else begin
                        grant_c = req1;
                    end
                    sel_d        = grant_c;
                    xact_d.we    = grant_c ? we1    : we0;
                    xact_d.addr  = grant_c ? addr1  : addr0;
                    xact_d.wdata = grant_c ? wdata1 : wdata0;
                    state_d      = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = xact_q.we ? S_WDATA : S_ACC;
`ifdef LC3_MIO_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WDATA: begin
                state_d = S_ACC;
            end
            S_ACC: begin
                if (R) begin
                    state_d = xact_q.we ? S_DONE : S_RD;
                end
`ifdef LC3_MIO_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    if (!xact_q.we) begin
                        rdata_d = TO_RDATA;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            S_RD: begin
                rdata_d = MDRbus;
                state_d = S_DONE;
            end
            S_DONE: begin
                last_d  = sel_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobe decode of the upcoming state, registered so outputs align with the state they belong to
    always_comb begin
        bus_en_d    = 1'b0;
        bus_out_d   = '0;
        ld_mar_d    = 1'b0;
        ld_mdr_wr_d = 1'b0;
        mio_en_d    = 1'b0;
        r_w_d       = 1'b0;
        acc_rd_d    = 1'b0;
        gate_mdr_d  = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        busy_d      = (state_d != S_IDLE);
        case (state_d)
            S_ADDR: begin
                bus_en_d  = 1'b1;
                bus_out_d = xact_d.addr;
                ld_mar_d  = 1'b1;
            end
            S_WDATA: begin
                bus_en_d    = 1'b1;
                bus_out_d   = xact_d.wdata;
                ld_mdr_wr_d = 1'b1;
            end
            S_ACC: begin
                mio_en_d = 1'b1;
                r_w_d    = xact_d.we;
                acc_rd_d = ~xact_d.we;
            end
            S_RD: begin
                gate_mdr_d = 1'b1;
            end
            S_DONE: begin
                done0_d = ~sel_d;
                done1_d = sel_d;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, transaction latch and registered strobes; reset aborts any transaction immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            xact_q      <= '0;
            rdata_q     <= '0;
            bus_en_q    <= 1'b0;
            bus_out_q   <= '0;
            ld_mar_q    <= 1'b0;
            ld_mdr_wr_q <= 1'b0;
            mio_en_q    <= 1'b0;
            r_w_q       <= 1'b0;
            acc_rd_q    <= 1'b0;
            gate_mdr_q  <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            xact_q      <= xact_d;
            rdata_q     <= rdata_d;
            bus_en_q    <= bus_en_d;
            bus_out_q   <= bus_out_d;
            ld_mar_q    <= ld_mar_d;
            ld_mdr_wr_q <= ld_mdr_wr_d;
            mio_en_q    <= mio_en_d;
            r_w_q       <= r_w_d;
            acc_rd_q    <= acc_rd_d;
            gate_mdr_q  <= gate_mdr_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            busy_q      <= busy_d;
        end
    end

`ifdef LC3_MIO_ARB_TIMEOUT_EN
    // Watchdog counter and abort flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // The MDR capture of a read must land in the exact cycle memory reports ready, so it is gated by R
    assign LD_MDR  = ld_mdr_wr_q | (acc_rd_q & R);
    assign bus_en  = bus_en_q;
    assign bus_out = bus_out_q;
    assign LD_MAR  = ld_mar_q;
    assign MIO_EN  = mio_en_q;
    assign R_W     = r_w_q;
    assign GateMDR = gate_mdr_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign busy    = busy_q;
    assign rdata   = rdata_q;

endmodule
